mmio_display: RTL and testbench

Parametrised memory-mapped display and LED controller on the CPU data bus. Generalises the single hard-wired segment latch at 16'hFFFF to NUM_DIGITS seven-segment digits and LED_W LEDs, all mapped in a 16-word window.
- Adds per-digit hex-decode or raw mode, per-digit blink, and registered readback.
- The top level uses `hit` to mux `rdata` against memory `q`.

---
 rtl/mmio_display_pkg.sv | 36 +++
 rtl/mmio_display_hex_to_seg7.sv | 13 +
 rtl/mmio_display.sv | 147 ++++++++++++++
 tb/tb_mmio_display.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_display_pkg.sv
// Shared constants for the memory-mapped display/LED controller:
// register offsets, blank patterns and the hex-to-seven-segment table.
package mmio_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam logic [3:0] OFF_HEXVAL = 4'd0;
  localparam logic [3:0] OFF_MODE   = 4'd1;
  localparam logic [3:0] OFF_RAW0   = 4'd2;
  localparam logic [3:0] OFF_LED    = 4'd14;
  localparam logic [3:0] OFF_LEGACY = 4'd15;

  localparam seg7_t SEG7_BLANK_AL = 7'b1111111;
  localparam seg7_t SEG7_BLANK_AH = 7'b0000000;

  // Active-low patterns, bit order g..a; entry n is the glyph for hex digit n
  localparam logic [15:0][6:0] SEG7_HEX_AL = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/mmio_display_hex_to_seg7.sv
// Combinational nibble to seven-segment decoder (bit order g..a) with selectable polarity.
module hex_to_seg7
  import mmio_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = ACTIVE_LOW ? SEG7_HEX_AL[nibble_i] : ~SEG7_HEX_AL[nibble_i];

endmodule

// File: rtl/mmio_display.sv
// Memory-mapped seven-segment display and LED controller occupying a 16-word window
// on the CPU data bus, with per-digit hex/raw mode, blink and registered readback.
module mmio_display
  import mmio_display_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 16,
  parameter int unsigned        DATA_W         = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR      = ADDR_W'(16'hFFF0),
  parameter int unsigned        NUM_DIGITS     = 4,
  parameter int unsigned        LED_W          = 8,
  parameter int unsigned        BLINK_DIV      = 25_000_000,
  parameter bit                 SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    wren,
  input  logic                    rden,
  output logic                    hit,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic [LED_W-1:0]        led
);

  localparam int unsigned      HEX_W     = 4 * NUM_DIGITS;
  localparam int unsigned      MODE_W    = 2 * NUM_DIGITS;
  localparam int unsigned      CNT_W     = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = SEG_ACTIVE_LOW ? SEG7_BLANK_AL : SEG7_BLANK_AH;

  logic [HEX_W-1:0]            hexval_q, hexval_d;
  logic [MODE_W-1:0]           mode_q, mode_d;
  logic [NUM_DIGITS-1:0][6:0]  raw_q, raw_d;
  logic [LED_W-1:0]            led_q, led_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        phase_q, phase_d;
  logic [DATA_W-1:0]           rdata_q, rdata_d;
  logic                        rvalid_q, rvalid_d;

  logic [3:0]                  off;
  logic                        wr_en;
  logic                        rd_en;
  logic [DATA_W-1:0]           rd_word;
  logic                        unused_wdata;

  assign hit          = (addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign off          = addr[3:0];
  assign wr_en        = wren && hit;
  assign rd_en        = rden && hit;
  assign unused_wdata = ^wdata;

  // Register writes; the legacy slot also forces digit 0 into raw mode
  always_comb begin
    hexval_d = hexval_q;
    mode_d   = mode_q;
    raw_d    = raw_q;
    led_d    = led_q;
    if (wr_en) begin
      case (off)
        OFF_HEXVAL: hexval_d = wdata[HEX_W-1:0];
        OFF_MODE:   mode_d   = wdata[MODE_W-1:0];
        OFF_LED:    led_d    = wdata[LED_W-1:0];
        OFF_LEGACY: begin
          raw_d[0]  = wdata[6:0];
          mode_d[0] = 1'b1;
        end
        default: begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (off == 4'(32'(OFF_RAW0) + i)) raw_d[i] = wdata[6:0];
          end
        end
      endcase
    end
  end

  // Readback mux samples pre-write register contents
  always_comb begin
    rd_word = '0;
    case (off)
      OFF_HEXVAL: rd_word = DATA_W'(hexval_q);
      OFF_MODE:   rd_word = DATA_W'(mode_q);
      OFF_LED:    rd_word = DATA_W'(led_q);
      OFF_LEGACY: rd_word = DATA_W'(raw_q[0]);
      default: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (off == 4'(32'(OFF_RAW0) + i)) rd_word = DATA_W'(raw_q[i]);
        end
      end
    endcase
    rdata_d  = rd_en ? rd_word : rdata_q;
    rvalid_d = rd_en;
  end

  // Free-running blink timer; phase flips on every wrap
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hexval_q <= '0;
      mode_q   <= '0;
      raw_q    <= '0;
      led_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      hexval_q <= hexval_d;
      mode_q   <= mode_d;
      raw_q    <= raw_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign led    = led_q;

  // Blanking overrides both hex and raw sources
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [6:0] dec;

    hex_to_seg7 #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dec (
      .nibble_i (hexval_q[4*i +: 4]),
      .seg_o    (dec)
    );

    assign seg[7*i +: 7] = (mode_q[NUM_DIGITS+i] && phase_q) ? SEG_BLANK :
                           mode_q[i]                         ? raw_q[i]  : dec;
  end

endmodule

// File: tb/tb_mmio_display.sv
// Scoreboard bench for mmio_display: reads push expected data, a negedge monitor
// pops and compares on rvalid; display/LED outputs are checked directly.
module tb_mmio_display;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] SA    = 7'b0001000;
  localparam logic [6:0] SF    = 7'b0001110;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr  = 16'h0000;
  logic [31:0] wdata = 32'h0;
  logic        wren  = 1'b0;
  logic        rden  = 1'b0;
  logic        hit;
  logic [31:0] rdata;
  logic        rvalid;
  logic [27:0] seg;
  logic [7:0]  led;

  int          checks = 0;
  int          passed = 0;
  int          k      = 0;
  logic [31:0] sb[$];

  mmio_display #(
    .ADDR_W         (16),
    .DATA_W         (32),
    .BASE_ADDR      (16'hFFF0),
    .NUM_DIGITS     (4),
    .LED_W          (8),
    .BLINK_DIV      (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .wren   (wren),
    .rden   (rden),
    .hit    (hit),
    .rdata  (rdata),
    .rvalid (rvalid),
    .seg    (seg),
    .led    (led)
  );

  always #5 clock = ~clock;

  // Edges since reset: blink phase model is (k/4)%2 with BLINK_DIV = 4
  always @(posedge clock) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 64'(rvalid), 64'(0));
      end else begin
        check("rdata", 64'(rdata), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wren  = 1'b1;
    tick();
    wren  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp);
    addr = a;
    rden = 1'b1;
    sb.push_back(exp);
    tick();
    rden = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] exp_seg;

    tick();
    tick();
    reset = 1'b0;
    tick();

    check("reset_rvalid", 64'(rvalid), 64'(0));
    check("reset_seg", 64'(seg), 64'({S0, S0, S0, S0}));
    check("reset_led", 64'(led), 64'(0));

    rd(16'hFFF0, 32'h0);
    rd(16'hFFF1, 32'h0);
    rd(16'hFFFE, 32'h0);
    rd(16'hFFF7, 32'h0);

    wr(16'hFFF0, 32'h0000_A3F1);
    check("hexval_seg", 64'(seg), 64'({SA, S3, SF, S1}));
    rd(16'hFFF0, 32'h0000_A3F1);

    wr(16'hFFFF, 32'h0000_0055);
    check("legacy_seg", 64'(seg), 64'({SA, S3, SF, 7'b1010101}));
    rd(16'hFFF1, 32'h0000_0001);
    rd(16'hFFFF, 32'h0000_0055);
    rd(16'hFFF2, 32'h0000_0055);

    addr = 16'h0100;
    #1;
    check("hit_outside", 64'(hit), 64'(0));
    addr = 16'hFFF3;
    #1;
    check("hit_inside", 64'(hit), 64'(1));
    wr(16'h0100, 32'h0000_0000);
    check("outside_write_seg", 64'(seg), 64'({SA, S3, SF, 7'b1010101}));
    rd(16'h0100, 32'hDEAD_BEEF);
    void'(sb.pop_back());

    wr(16'hFFFE, 32'h0000_003C);
    check("led_3c", 64'(led), 64'(8'h3C));
    addr  = 16'hFFFE;
    wdata = 32'hFFFF_FFA5;
    wren  = 1'b1;
    rden  = 1'b1;
    sb.push_back(32'h0000_003C);
    tick();
    wren  = 1'b0;
    rden  = 1'b0;
    check("led_a5", 64'(led), 64'(8'hA5));
    rd(16'hFFFE, 32'h0000_00A5);

    wr(16'hFFF1, 32'h0000_0020);
    for (int i = 0; i < 16; i++) begin
      exp_seg = {SA, S3, (((k / 4) % 2) == 1) ? BLANK : SF, S1};
      check("blink_seg", 64'(seg), 64'(exp_seg));
      tick();
    end

    addr  = 16'hFFF0;
    wdata = 32'h0000_FFFF;
    wren  = 1'b1;
    rden  = 1'b1;
    reset = 1'b1;
    tick();
    wren  = 1'b0;
    rden  = 1'b0;
    reset = 1'b0;
    check("rvalid_after_reset", 64'(rvalid), 64'(0));
    check("seg_after_reset", 64'(seg), 64'({S0, S0, S0, S0}));
    check("led_after_reset", 64'(led), 64'(0));
    rd(16'hFFF0, 32'h0);
    rd(16'hFFF1, 32'h0);

    tick();
    tick();
    check("sb_drain", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
